// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - pin-side and ALU-side bus of the ALU command sequencer
// master drives pins and the ALU result; slave is the sequencer itself.
interface alu_cmd_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              ena;
  logic [DATA_W-1:0] ui_in;
  logic [7:0]        uio_in;
  logic [DATA_W-1:0] uo_out;
  logic [7:0]        uio_out;
  logic [7:0]        uio_oe;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_s;
  logic [DATA_W-1:0] alu_result;

  modport master (
    output ena, ui_in, uio_in, alu_result,
    input  uo_out, uio_out, uio_oe, alu_a, alu_b, alu_s
  );

  modport slave (
    input  ena, ui_in, uio_in, alu_result,
    output uo_out, uio_out, uio_oe, alu_a, alu_b, alu_s
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - serial operand/opcode loader and repeat sequencer for alu_8bits
// ALU_SEQ_REPEAT_EN enables the repeat count and result feedback into operand A.
module alu_cmd_sequencer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input logic                clk,
  input logic                rst_n,
  alu_cmd_sequencer_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic              r_wr, r_wr_prev, r_ack, r_ack_prev;
  logic [1:0]        r_sel;
  logic [DATA_W-1:0] r_a, r_b, r_result;
  logic [1:0]        r_s;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  logic [DATA_W-1:0] w_a_nxt, w_b_nxt, w_result_nxt;
  logic [1:0]        w_s_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_err_nxt;
  logic              w_wr_rise, w_ack_rise, w_busy, w_valid;
  logic              w_unused;

  assign w_wr_rise  = r_wr & ~r_wr_prev;
  assign w_ack_rise = r_ack & ~r_ack_prev;
  assign w_busy     = (r_state == ST_EXEC);
  assign w_valid    = (r_state == ST_DONE);
  assign w_unused   = &{1'b0, bus.uio_in[7:4]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_data     <= '0;
      r_wr       <= 1'b0;
      r_wr_prev  <= 1'b0;
      r_ack      <= 1'b0;
      r_ack_prev <= 1'b0;
      r_sel      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_s        <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_err      <= 1'b0;
    end else if (bus.ena) begin
      r_state    <= w_state_nxt;
      r_data     <= bus.ui_in;
      r_wr       <= bus.uio_in[0];
      r_wr_prev  <= r_wr;
      r_ack      <= bus.uio_in[3];
      r_ack_prev <= r_ack;
      r_sel      <= bus.uio_in[2:1];
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_s        <= w_s_nxt;
      r_cnt      <= w_cnt_nxt;
      r_result   <= w_result_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_s_nxt      = r_s;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_err_nxt    = r_err;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_rise) begin
          case (r_sel)
            2'b00: w_a_nxt = r_data;
            2'b01: w_b_nxt = r_data;
            2'b10: begin
              w_s_nxt     = r_data[1:0];
`ifdef ALU_SEQ_REPEAT_EN
              w_cnt_nxt   = r_data[3 +: CNT_W];
`else
              w_cnt_nxt   = '0;
`endif
              w_state_nxt = ST_EXEC;
            end
            default: ;
          endcase
        end
      end
      ST_EXEC: begin
        w_result_nxt = bus.alu_result;
        if (w_wr_rise) w_err_nxt = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
`ifdef ALU_SEQ_REPEAT_EN
          w_a_nxt   = bus.alu_result;
`endif
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (w_wr_rise) w_err_nxt = 1'b1;
        // Ack wins over a coincident stray write: the host is closing the transaction.
        if (w_ack_rise) begin
          w_err_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.uo_out  = r_result;
  assign bus.uio_out = {1'b0, r_err, w_valid, w_busy, 4'b0000};
  assign bus.uio_oe  = 8'hF0;
  assign bus.alu_a   = r_a;
  assign bus.alu_b   = r_b;
  assign bus.alu_s   = r_s;
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command sequencer between the Tiny Tapeout pin interface and the combinational `alu_8bits` datapath. It loads operand A, operand B and an opcode byte serially through `ui_in` under strobe control, and drives the ALU. It iterates the operation a programmable number of times, feeding each result back into A, then holds the result on `uo_out` until the host acknowledges it. It instantiates directly inside the `tt_um_*` top and replaces the direct pin-to-ALU wiring.

## Interface
- `DATA_W`, 8: operand and result width.
- `CNT_W`, 4: repeat-count width.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `ena` in 1: high enables operation; low freezes all state.
- `ui_in` in 8: data byte to be written.
- `uio_in` in 8: [0] write strobe, [2:1] field select (00 A, 01 B, 10 opcode+go, 11 reserved), [3] result ack; [7:4] ignored.
- `uo_out` out 8: result register.
- `uio_out` out 8: [4] busy, [5] result_valid, [6] err (sticky), [7] 0, [3:0] 0.
- `uio_oe` out 8: constant 8'hF0.
- `alu_a`, `alu_b` out 8: ALU operands (registered).
- `alu_s` out 2: ALU selector (registered); 00 add, 01 sub, 10 AND, 11 OR.
- `alu_result` in 8: combinational ALU result.

## Operation
- Input sampling: each enabled cycle registers `ui_in`, `uio_in[0]`, `uio_in[2:1]` and `uio_in[3]`; previous strobe and ack samples are kept. wr_rise = sample & ~prev; ack_rise likewise.
- Opcode byte: [1:0] S, [6:3] repeat count N, [2] and [7] ignored.
- State IDLE:
  - wr_rise with sel 00 loads A.
  - wr_rise with sel 01 loads B.
  - wr_rise with sel 10 loads S and N, then goes to EXEC.
  - sel 11 is a no-op.
- State EXEC, one ALU evaluation per cycle:
  - The result register captures `alu_result`.
  - If cnt = 0, go to DONE.
  - Otherwise A <= `alu_result` and cnt decrements.
  - Total EXEC cycles = N+1.
- State DONE:
  - result_valid = 1 and `uo_out` holds the result.
  - ack_rise clears valid, clears err and goes to IDLE.
  - A, B and S are retained, so a new opcode write reruns using the current A.
- busy = 1 in EXEC; valid = 1 in DONE only.
- A wr_rise in EXEC or DONE is ignored and sets err. err persists until ack_rise in DONE or reset.
- An ack_rise outside DONE is ignored, with no error.
- Arithmetic is the ALU's 8-bit result, wrapped modulo 256. No carry or flags are captured.
- `ena` = 0: no state, register or sample updates; outputs hold.
- Reset takes priority over everything, including mid-EXEC.

## Timing
- Reset (rst_n low at an edge):
  - state IDLE.
  - A, B, S, cnt, result, samples = 0.
  - `uo_out` = 0, `uio_out` = 0, `alu_a`/`alu_b`/`alu_s` = 0.
  - `uio_oe` = F0 unconditionally.
- The strobe pin and `ui_in` are sampled at edge k. The field register updates at edge k+1.
- The opcode write edge (k+1) enters EXEC, so busy is high from k+1.
- EXEC cycles are k+1 .. k+N+1.
- valid rises at edge k+N+2 with the final result.
- Ack is sampled at edge j; DONE→IDLE and valid falls at edge j+1.
- The strobe must return low for at least one sampled cycle between writes. A held strobe is a single write.
- The ALU is combinational. `alu_a`/`alu_b`/`alu_s` are stable for the whole EXEC cycle.

## Configuration
- `ALU_SEQ_REPEAT_EN` defined:
  - Opcode [6:3] loads cnt.
  - Result feedback into A is active.
- `ALU_SEQ_REPEAT_EN` undefined:
  - cnt is forced to 0 and opcode [6:3] is ignored.
  - Every command takes exactly one EXEC cycle.
  - A is never overwritten by the result.

## Test plan
- Reset: hold rst_n low 2 cycles with random pins → `uo_out` = 00, `uio_out` = 00, `uio_oe` = F0, `alu_a`/`alu_b`/`alu_s` = 0, state IDLE.
- Single op: write A = 15, B = 27, opcode 00 → busy for 1 cycle, then valid and `uo_out` = 3C. Ack → valid clears at the next edge. Repeat with A = F0, B = 20 → `uo_out` = 10 (wrap).
- Repeat, macro on: A = 03, B = 02, opcode 18 (add, N = 3) → busy exactly 4 cycles, `uo_out` = 0B. With macro off, the same stimulus → 1 cycle, `uo_out` = 05.
- Protocol error: write B = 55 during EXEC → B unchanged and err = 1. The final result is unaffected. Ack → err and valid clear.
- Reset mid-operation: opcode 78 (N = 15), assert rst_n low on the 3rd EXEC cycle → next edge IDLE, all outputs 0. A following single op works normally.
- Enable gating: drop `ena` mid-EXEC for 5 cycles → state and cnt frozen. After `ena` returns, the remaining cycles complete with the correct result. Strobes during `ena` = 0 have no effect.
